// File: rtl/pcss_node_pkg.sv
// pcss_node_pkg: shared flit/timestamp widths, queue-entry layout and late-window helper.
// Latency: n/a (types, constants and a constant function only).
// Backpressure: n/a.
package pcss_node_pkg;

  localparam int PCSS_FW       = 59;
  localparam int PCSS_TS_W     = 8;
  // A head whose timestamp trails tik_cnt by less than this is late, not far-future.
  localparam int PCSS_LATE_WIN = 1 << (PCSS_TS_W - 1);

  // One queued host flit: config marker, release time step, payload.
  typedef struct packed {
    logic                 cfg;
    logic [PCSS_TS_W-1:0] ts;
    logic [PCSS_FW-1:0]   flit;
  } q_entry_t;

  // Late window (half the timestamp space) rescaled for a non-default timestamp width.
  function automatic int late_win(input int ts_w);
    if (ts_w <= PCSS_TS_W) begin
      return PCSS_LATE_WIN >> (PCSS_TS_W - ts_w);
    end
    return PCSS_LATE_WIN << (ts_w - PCSS_TS_W);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with show-ahead head, occupancy count and full/empty flags.
// Latency: a push at edge k is visible on head after edge k (when the FIFO was empty).
// Backpressure: pushes while full and pops while empty are ignored; callers gate on full/empty.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  // Storage array: written on accepted pushes only, no reset needed since reads are gated by empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Pointers wrap naturally (power-of-2 depth); count tracks occupancy for full/empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/node_spike_scheduler.sv
// node_spike_scheduler: tik time base plus timestamp-gated, credit-controlled flit injector for a PCSS node.
// Latency: 2 cycles minimum from accepted push to flit_out_wr; spikes also wait until tik_cnt reaches ts.
// Backpressure: in_ready drops when the queue is full; release stalls at zero credits or on a future-ts head.
module node_spike_scheduler
  import pcss_node_pkg::*;
#(
  parameter int FW       = PCSS_FW,
  parameter int TS_W     = PCSS_TS_W,
  parameter int TIK_HALF = 128,
  parameter int DEPTH    = 16,
  parameter int CREDITS  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     run,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_cfg,
  input  logic [TS_W-1:0]          in_ts,
  input  logic [FW-1:0]            in_flit,
  output logic                     tik,
  output logic [TS_W-1:0]          tik_cnt,
  output logic                     flit_out_wr,
  output logic [FW-1:0]            flit_out,
  input  logic                     credit_ret,
  output logic                     late,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int DIV_W    = (TIK_HALF > 1) ? $clog2(TIK_HALF) : 1;
  localparam int CRD_W    = $clog2(CREDITS + 1);
  localparam int LATE_WIN = late_win(TS_W);

  typedef struct packed {
    logic            cfg;
    logic [TS_W-1:0] ts;
    logic [FW-1:0]   flit;
  } entry_t;

  entry_t           push_ent;
  entry_t           head_ent;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             fire;
  logic             eligible;
  logic             ts_match;
  logic             ts_late;
  logic [TS_W-1:0]  ts_diff;
  logic [DIV_W-1:0] div_cnt;
  logic             div_wrap;
  logic [CRD_W-1:0] credits;

  // Host side: accept whenever there is room; no pass-through around a full queue.
  assign in_ready = ~fifo_full;
  assign push     = in_valid & ~fifo_full;

  // Pack the incoming host beat into a queue entry.
  always_comb begin
    push_ent      = '0;
    push_ent.cfg  = in_cfg;
    push_ent.ts   = in_ts;
    push_ent.flit = in_flit;
  end

  sync_fifo #(
    .W     ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat (push_ent),
    .pop      (fire),
    .head     (head_ent),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign div_wrap = (div_cnt == DIV_W'(TIK_HALF - 1));

  // Tik divider: toggles tik every TIK_HALF running cycles; tik_cnt advances on each falling toggle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      tik     <= 1'b0;
      tik_cnt <= '0;
    end else if (run) begin
      if (div_wrap) begin
        div_cnt <= '0;
        tik     <= ~tik;
        if (tik) begin
          tik_cnt <= tik_cnt + TS_W'(1);
        end
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

  // Head age in modular time: zero is on time, the lower half-space is late, the rest is future.
  assign ts_diff  = tik_cnt - head_ent.ts;
  assign ts_match = (ts_diff == '0);
  assign ts_late  = (ts_diff != '0) && (ts_diff < TS_W'(LATE_WIN));
  assign eligible = head_ent.cfg | ts_match | ts_late;
  assign fire     = ~fifo_empty & (credits != '0) & eligible;

  // Registered node-side outputs: strobe, payload and late flag line up in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flit_out_wr <= 1'b0;
      flit_out    <= '0;
      late        <= 1'b0;
    end else begin
      flit_out_wr <= fire;
      late        <= fire & ~head_ent.cfg & ~ts_match;
      if (fire) begin
        flit_out <= head_ent.flit;
      end
    end
  end

  // Credit counter: release consumes, return refunds, both together cancel, returns saturate at CREDITS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credits <= CRD_W'(CREDITS);
    end else if (fire && !credit_ret) begin
      credits <= credits - CRD_W'(1);
    end else if (!fire && credit_ret && (credits < CRD_W'(CREDITS))) begin
      credits <= credits + CRD_W'(1);
    end
  end

endmodule

// File: doc/node_spike_scheduler.md
# node_spike_scheduler

Drives a PCSS `node` flit input from a host-side stream of timestamped flits. Generates the node's `tik` time base and holds incoming flits in a FIFO, releasing each one when the tik count reaches its timestamp. Config flits bypass the timestamp gate. All releases obey credit-based flow control toward the node. Sits between the host/stimulus interface and the `node` instance; it replaces ad-hoc tik and injection logic in system builds.

## Interface
Parameters:
- `FW`, 59, flit width.
- `TS_W`, 8, timestamp and tik-count width.
- `TIK_HALF`, 128, clock cycles per tik half-period (≥2).
- `DEPTH`, 16, FIFO entries (power of 2, ≥2).
- `CREDITS`, 4, initial and maximum credits toward the node (≥1).

Ports:
- `clk`, input, 1: the single clock for the block.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `run`, input, 1: 1 = work mode (tik advances); 0 = tik frozen.
- `in_valid`, input, 1: host flit valid.
- `in_ready`, output, 1: FIFO can accept this cycle.
- `in_cfg`, input, 1: flit is a config flit; `in_ts` is ignored.
- `in_ts`, input, TS_W: release tik count.
- `in_flit`, input, FW: flit payload.
- `tik`, output, 1: tik to the node.
- `tik_cnt`, output, TS_W: current time step.
- `flit_out_wr`, output, 1: flit write strobe to the node's `flit_in_wr`.
- `flit_out`, output, FW: flit payload to the node's `flit_in`.
- `credit_ret`, input, 1: credit pulse from the node's `credit_out`.
- `late`, output, 1: one-cycle pulse when a spike flit is released after its timestamp.
- `fifo_count`, output, log2(DEPTH)+1: current occupancy.

## Operation
- Reset values: all outputs 0, except `in_ready`=1. Reset clears the FIFO, the credit counter (set to CREDITS), the tik divider, and `tik_cnt`. Reset mid-operation discards all queued flits; no partial flit is emitted.
- Push: `in_valid & in_ready` writes {cfg, ts, flit} into the FIFO. `in_ready` = !full. There is no same-cycle pass-through when full.
- Tik generator:
  - While `run`=1, a divider counts 0..TIK_HALF-1. At TIK_HALF-1 it wraps and `tik` toggles.
  - On a 1→0 toggle, `tik_cnt` increments mod 2^TS_W. Wrap from 255 to 0 is silent.
  - While `run`=0, the divider, `tik` and `tik_cnt` hold their values.
- Release condition for the FIFO head: FIFO non-empty, credits > 0, and one of the following:
  - head is a config flit; or
  - head ts == `tik_cnt`; or
  - head is late: (`tik_cnt` − ts) mod 2^TS_W lies in [1, 2^(TS_W−1)−1]. A late release pulses `late`.
- Any other head (a future timestamp) blocks the FIFO. Strict in-order release; no reordering.
- Release behaviour: pop the head, register `flit_out`/`flit_out_wr` (a one-cycle strobe), and decrement credits. `flit_out` holds its last value when `flit_out_wr`=0.
- Credits:
  - `credit_ret` increments the credit count.
  - A release and a return in the same cycle leave the count unchanged.
  - A return at CREDITS saturates (ignored).
  - At 0 credits, releases stall.
- At most one release per cycle.
- A push and a pop in the same cycle are both legal; occupancy is unchanged.

## Timing
- Push at edge k → the head is visible after edge k; the earliest `flit_out_wr` is high in the cycle following edge k+1 (2-cycle minimum latency).
- A tik_cnt change at edge t makes matching flits eligible at edge t+1.
- `run` rising: the first tik toggle occurs TIK_HALF cycles later.
- `late`, `flit_out_wr` and `flit_out` are registered and aligned in the same cycle.

## Structure
- Shared package `pcss_node_pkg`: FW, TS_W defaults, the queue-entry typedef {cfg, ts, flit}, and the late-window constant 2^(TS_W−1).
- Natural sub-module: `sync_fifo` (parameterised width/depth, count output, full/empty).
- Tik divider, release decision, and credit counter stay in the top level.

## Test plan
- Config burst: with `run`=0, push 45 cfg flits, with `credit_ret` pulsed 2 cycles after each write. Required: all 45 are emitted in order, tik stays 0, and credits never go below 0.
- Timed spikes: `run`=1, TIK_HALF=128. Push spikes with ts=2 and ts=5. Required: each `flit_out_wr` occurs the cycle after `tik_cnt` reaches 2 (cycle ≈512 after `run`) and 5 respectively.
- Credit stall: CREDITS=4, no returns, 6 cfg flits. Required: exactly 4 strobes. One `credit_ret` → the 5th strobe 1 cycle later. A return together with a release → count unchanged.
- Full FIFO: push 17 flits with the head blocked by ts=9. Required: `in_ready`=0 after 16, `fifo_count`=16. Simultaneous pop and push once the head releases.
- Late and wrap: push ts=3 when `tik_cnt`=7 → immediate release with a `late` pulse. Push ts=0 at `tik_cnt`=255 → released after the wrap to 0, with no `late` pulse.
- Reset mid-run: assert `rst_n`=0 with 5 queued flits. Required: all outputs go to reset values asynchronously; after release, `fifo_count`=0 and no stale flit is emitted.
